// File: rtl/nand_gate_checker.sv
// Stimulus/response checker for a two-input NAND gate: walks the four truth-table
// vectors, samples y after SETTLE cycles and logs mismatches. Optional multi-pass
// accumulation is enabled by defining NAND_GATE_CHECKER_LOOP_EN.
module nand_gate_checker #(
   parameter int unsigned SETTLE = 2   // legal range 1..15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [7:0] err_cnt
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DRIVE  = 2'd1;
   localparam logic [1:0] S_SAMPLE = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   localparam logic [3:0] SCNT_LAST = 4'(SETTLE - 1);

   logic [1:0] state;
   logic [1:0] idx;
   logic [3:0] scnt;
   logic       exp_y;

   assign exp_y = ~(idx[1] & idx[0]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         idx      <= 2'd0;
         scnt     <= 4'd0;
         fail_vec <= 4'd0;
         err_cnt  <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  fail_vec <= 4'd0;
                  err_cnt  <= 8'd0;
                  idx      <= 2'd0;
                  scnt     <= 4'd0;
                  state    <= S_DRIVE;
               end
            end
            S_DRIVE: begin
               scnt <= scnt + 4'd1;
               if (scnt == SCNT_LAST)
                  state <= S_SAMPLE;
            end
            S_SAMPLE: begin
               // y is only looked at here, so it never reaches an output combinationally
               if (y != exp_y) begin
                  fail_vec[idx] <= 1'b1;
                  if (err_cnt != 8'hFF)
                     err_cnt <= err_cnt + 8'd1;
               end
               if (idx == 2'd3) begin
                  state <= S_DONE;
               end else begin
                  idx   <= idx + 2'd1;
                  scnt  <= 4'd0;
                  state <= S_DRIVE;
               end
            end
            S_DONE: begin
`ifdef NAND_GATE_CHECKER_LOOP_EN
               // back-to-back passes keep accumulating results
               if (start) begin
                  idx   <= 2'd0;
                  scnt  <= 4'd0;
                  state <= S_DRIVE;
               end else begin
                  state <= S_IDLE;
               end
`else
               state <= S_IDLE;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign busy = (state == S_DRIVE) || (state == S_SAMPLE);
   assign done = (state == S_DONE);
   assign a    = busy & idx[1];
   assign b    = busy & idx[0];
   assign pass = (fail_vec == 4'd0);

endmodule

// File: tb/tb_nand_gate_checker.sv
// Self-checking bench for nand_gate_checker: run-time behavioural model plus
// directed scenarios with hand-computed expectations (SETTLE=2).
module tb_nand_gate_checker;

   localparam int S = 2;
   localparam int P = S + 1;       // cycles per vector
   localparam int N = 4 * P + 1;   // done cycle relative to E0
`ifdef NAND_GATE_CHECKER_LOOP_EN
   localparam bit LOOP = 1'b1;
`else
   localparam bit LOOP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, start, y;
   logic       a, b, busy, done, pass;
   logic [3:0] fail_vec;
   logic [7:0] err_cnt;

   int mode;          // gate under test: 0 good, 1 stuck-at-1, 2 stuck-at-0
   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   nand_gate_checker #(.SETTLE(S)) dut (
      .clk(clk), .rst(rst), .start(start), .y(y),
      .a(a), .b(b), .busy(busy), .done(done), .pass(pass),
      .fail_vec(fail_vec), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   function automatic logic gate(input int m, input logic ga, input logic gb);
      case (m)
         1:       return 1'b1;
         2:       return 1'b0;
         default: return !(ga && gb);
      endcase
   endfunction

   always_comb y = gate(mode, a, b);

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: run_t = cycles since the accepting edge (0 = not running).
   int         run_t = 0;
   logic [3:0] m_fv = 4'd0;
   int         m_ec = 0;
   int         mv;
   logic       mgot, mwant;

   always @(posedge clk) begin
      if (rst) begin
         run_t = 0; m_fv = 4'd0; m_ec = 0;
      end else if (run_t == 0) begin
         if (start) begin
            m_fv = 4'd0; m_ec = 0; run_t = 1;
         end
      end else if (run_t == N) begin
         run_t = (LOOP && start) ? 1 : 0;
      end else begin
         if ((run_t - 1) % P == P - 1) begin
            mv    = (run_t - 1) / P;
            mwant = (mv == 3) ? 1'b0 : 1'b1;
            mgot  = gate(mode, mv[1], mv[0]);
            if (mgot != mwant) begin
               m_fv[mv] = 1'b1;
               if (m_ec < 255) m_ec++;
            end
         end
         run_t++;
      end
   end

   int   cv;
   logic e_busy, e_done;
   always @(negedge clk) begin
      if (chk_en) begin
         e_busy = (run_t >= 1) && (run_t < N);
         e_done = (run_t == N);
         cv     = (run_t >= 1) ? (run_t - 1) / P : 0;
         chk("model busy", busy, e_busy);
         chk("model done", done, e_done);
         chk("model a", a, e_busy && cv[1]);
         chk("model b", b, e_busy && cv[0]);
         chk("model fail_vec", fail_vec, m_fv);
         chk("model err_cnt", err_cnt, m_ec);
         chk("model pass", pass, m_fv == 4'd0);
      end
   end

   // Single run from IDLE; optional stray start at cycle extra_at.
   task automatic run(input int m, input int extra_at, input bit chk_seq,
                      input logic [3:0] efv, input int eec, input string tag);
      int k_done, ndone;
      int seq [12] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3};
      mode = m;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      k_done = 0;
      for (int k = 1; k <= 60; k++) begin
         if (k > 1) @(negedge clk);
         start = (k == extra_at);
         if (chk_seq && k <= 12) chk({tag, " ab seq"}, {a, b}, seq[k-1]);
         if (done) begin k_done = k; break; end
      end
      start = 1'b0;
      chk({tag, " done cycle"}, k_done, 13);
      chk({tag, " fail_vec"}, fail_vec, efv);
      chk({tag, " err_cnt"}, err_cnt, eec);
      chk({tag, " pass"}, pass, efv == 4'd0);
      ndone = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      chk({tag, " extra done"}, ndone, 0);
   endtask

   int dcyc [3];
   int nd, ndone_r, held_ec;
   logic [3:0] held_fv;

   initial begin
      rst = 1'b1; start = 1'b0; mode = 0;
      @(posedge clk);
      chk_en = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("reset a", a, 0);
      chk("reset b", b, 0);
      chk("reset busy", busy, 0);
      chk("reset done", done, 0);
      chk("reset pass", pass, 1);
      chk("reset fail_vec", fail_vec, 0);
      chk("reset err_cnt", err_cnt, 0);

      run(0, 0, 1'b1, 4'b0000, 0, "good");
      run(1, 0, 1'b0, 4'b1000, 1, "stuck1");
      run(2, 0, 1'b0, 4'b0111, 3, "stuck0");
      run(0, 5, 1'b0, 4'b0000, 0, "stray start");

      // Reset during SAMPLE of vector 2 with failures already logged
      mode = 2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int k = 1; k < 9; k++) @(negedge clk);
      chk("rst pre fail_vec", fail_vec, 4'b0011);
      chk("rst pre a", a, 1);
      chk("rst pre b", b, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst busy", busy, 0);
      chk("rst a", a, 0);
      chk("rst b", b, 0);
      chk("rst fail_vec", fail_vec, 0);
      chk("rst err_cnt", err_cnt, 0);
      chk("rst pass", pass, 1);
      ndone_r = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (done) ndone_r++;
      end
      chk("rst no done", ndone_r, 0);

      // start held high across three passes, stuck-at-1 gate
      mode = 1;
      nd = 0; held_ec = -1; held_fv = 4'hF;
      @(negedge clk); start = 1'b1;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (done) begin
            dcyc[nd] = k;
            nd++;
            if (nd == 3) begin
               held_ec = err_cnt; held_fv = fail_vec; start = 1'b0;
               break;
            end
         end
      end
      start = 1'b0;
      chk("held done count", nd, 3);
      if (nd == 3) begin
         chk("held first done", dcyc[0], 13);
         chk("held spacing 1", dcyc[1] - dcyc[0], LOOP ? 13 : 14);
         chk("held spacing 2", dcyc[2] - dcyc[1], LOOP ? 13 : 14);
      end
      chk("held err_cnt", held_ec, LOOP ? 3 : 1);
      chk("held fail_vec", held_fv, 4'b1000);
      repeat (2) @(negedge clk);
      chk("held idle busy", busy, 0);
      repeat (3) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish (tests %0d, failed %0d)", tests, fails);
      $fatal(1);
   end

endmodule
